dcache_fill_buffer: RTL and testbench
=====================================

// Module: dcache_fill_buffer
// PURPOSE
//   Line-refill assembler that sits directly upstream of the dcache data SRAM write port.
//   - Accepts one refill request (target row plus critical-word offset) at a time.
//   - Collects WIDTH/WORD_SIZE memory beats in wrap-around order, starting at the critical word.
//   - Forwards the critical word to the core early.
//   - Merges core stores that hit the in-flight line.
//   - Commits the assembled line to the SRAM in a single full-mask write cycle.
// PARAMETERS
//   WIDTH         512  line width in bits (SRAM row width)
//   LOG_NUM_ROWS  9    SRAM row-address width
//   WORD_SIZE     64   beat width and SRAM write-enable granularity
//   WORDS         WIDTH/WORD_SIZE (localparam, 8); WORD_IDX = $clog2(WORDS) (localparam, 3)
// PORTS
//   clk          in   1             clock, rising edge
//   reset_n      in   1             asynchronous active-low reset
//   req_valid    in   1             refill request valid
//   req_ready    out  1             high only in IDLE
//   req_row      in   LOG_NUM_ROWS  target SRAM row
//   req_word     in   WORD_IDX      critical word index = first beat's word
//   beat_valid   in   1             memory beat valid
//   beat_ready   out  1             high only in FILL
//   beat_data    in   WORD_SIZE     memory beat payload
//   st_valid     in   1             store-merge valid (store hits the line being filled)
//   st_ready     out  1             high only in FILL
//   st_word      in   WORD_IDX      word index of the store
//   st_data      in   WORD_SIZE     store data (whole word)
//   crit_valid   out  1             one-cycle pulse: critical word available
//   crit_data    out  WORD_SIZE     critical word; held until the next crit_valid
//   busy         out  1             state != IDLE
//   done         out  1             one-cycle pulse, coincident with the SRAM write
//   writeAddr    out  LOG_NUM_ROWS  SRAM write row
//   writeData    out  WIDTH         SRAM write data; word i = writeData[i*WORD_SIZE +: WORD_SIZE]
//   writeEnable  out  WORDS         SRAM per-word write enables
// BEHAVIOUR
//   Reset: async on reset_n low.
//   - State goes to IDLE; every output register clears to 0 (writeEnable, writeAddr, writeData,
//     crit_valid, crit_data, done).
//   - Line, store-mask and counters clear to 0.
//   - Reset mid-FILL or mid-WRITE abandons the line; no SRAM write occurs.
//   FSM states: IDLE -> FILL -> WRITE -> IDLE. All outputs are registered or a pure decode of state.
//   IDLE
//   - On req_valid: latch row <- req_row, ptr <- req_word, cnt <- 0, smask <- 0; go to FILL.
//   FILL
//   - Beat accepted when beat_valid && beat_ready:
//     - line[ptr] <- beat_data unless smask[ptr] is set (store data wins over memory data).
//     - ptr <- (ptr+1) mod WORDS (wrap 7 -> 0); cnt <- cnt+1.
//   - First accepted beat (cnt==0): next cycle crit_valid=1 and crit_data=beat_data, even if a
//     store targets that word.
//   - Beat with cnt==WORDS-1: go to WRITE.
//   - Store accepted when st_valid && st_ready:
//     - line[st_word] <- st_data; smask[st_word] <- 1.
//     - Applies whether or not that word has already arrived.
//     - Store and beat to the same word in the same cycle: store data wins.
//   WRITE (exactly 1 cycle)
//   - writeEnable = all ones, writeAddr = row, writeData = line (final beat and any same-cycle
//     store included).
//   - done = 1 this cycle; next cycle go to IDLE with writeEnable = 0.
//   - Stores and beats are not accepted; st_ready = beat_ready = 0.
//   Timing and throughput
//   - Latency: last beat accepted at cycle N -> SRAM write at cycle N+1.
//   - Earliest next req_ready: cycle N+2.
//   - Beats may stall arbitrarily (beat_valid low); no timeout.
//   - Beats or stores presented outside FILL are ignored (ready is low).
// TESTING
//   1. req row=5, word=0; beats 0x10..0x17 back-to-back -> crit_data=0x10 one cycle after beat 0;
//      WRITE row 5, we=8'hFF, word i = 0x10+i; done pulses once.
//   2. req row=511, word=6; beats A..H -> words 6,7,0..5 = A..H; crit_data=A; ptr wraps 7->0
//      correctly.
//   3. Store word 3 = 0xDEAD before beat for word 3, another store to word 1 after its beat ->
//      written line has word3=0xDEAD, word1=store data; the other words come from memory.
//   4. Store and beat to word 2 in the same cycle -> word 2 = store data;
//      beat_valid gaps of 0-5 cycles -> same final line.
//   5. reset_n low during FILL after 4 beats -> outputs 0 immediately, no writeEnable ever pulses;
//      new req after reset fills cleanly.
//   6. req_valid held high through WRITE -> second request accepted only once back in IDLE;
//      writeEnable is a single one-cycle pulse per line.

Source files
------------

// File: rtl/dcache_fill_buffer.sv
// Purpose: assembles one dcache line from wrap-ordered memory beats, merges in-flight stores, commits the full row.
// Latency: critical word 1 cycle after the first beat; SRAM write 1 cycle after the last beat; req_ready again 1 cycle later.
// Backpressure: req_ready only in IDLE, beat_ready/st_ready only in FILL; beats may stall indefinitely.
//
// Ports:
//   clk, reset_n                 clock (rising edge) and async active-low reset
//   req_valid/req_ready          refill request handshake; req_row = target row, req_word = critical word
//   beat_valid/beat_ready        memory beat handshake; beat_data = beat payload
//   st_valid/st_ready            store-merge handshake; st_word/st_data = whole-word store
//   crit_valid, crit_data        one-cycle pulse with the critical word; data held until the next pulse
//   busy, done                   not-idle flag; one-cycle pulse coincident with the SRAM write
//   writeAddr/Data/Enable        SRAM write port (word i = writeData[i*WORD_SIZE +: WORD_SIZE])
module dcache_fill_buffer #(
  parameter int WIDTH        = 512,
  parameter int LOG_NUM_ROWS = 9,
  parameter int WORD_SIZE    = 64,
  localparam int WORDS       = WIDTH / WORD_SIZE,
  localparam int WORD_IDX    = $clog2(WORDS)
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic [LOG_NUM_ROWS-1:0] req_row,
  input  logic [WORD_IDX-1:0]     req_word,
  input  logic                    beat_valid,
  output logic                    beat_ready,
  input  logic [WORD_SIZE-1:0]    beat_data,
  input  logic                    st_valid,
  output logic                    st_ready,
  input  logic [WORD_IDX-1:0]     st_word,
  input  logic [WORD_SIZE-1:0]    st_data,
  output logic                    crit_valid,
  output logic [WORD_SIZE-1:0]    crit_data,
  output logic                    busy,
  output logic                    done,
  output logic [LOG_NUM_ROWS-1:0] writeAddr,
  output logic [WIDTH-1:0]        writeData,
  output logic [WORDS-1:0]        writeEnable
);

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_e;

  state_e                              state_q, state_d;
  logic [LOG_NUM_ROWS-1:0]             row_q, row_d;
  logic [WORD_IDX-1:0]                 ptr_q, ptr_d;
  logic [WORD_IDX-1:0]                 cnt_q, cnt_d;
  logic [WORDS-1:0]                    smask_q, smask_d;
  logic [WORDS-1:0][WORD_SIZE-1:0]     line_q, line_d;
  logic                                crit_valid_q, crit_valid_d;
  logic [WORD_SIZE-1:0]                crit_data_q, crit_data_d;
  logic                                done_q, done_d;
  logic [WORDS-1:0]                    we_q, we_d;
  logic [LOG_NUM_ROWS-1:0]             waddr_q, waddr_d;
  logic [WIDTH-1:0]                    wdata_q, wdata_d;

  logic beat_acc, st_acc, last_beat;

  assign req_ready  = (state_q == IDLE);
  assign beat_ready = (state_q == FILL);
  assign st_ready   = (state_q == FILL);
  assign busy       = (state_q != IDLE);

  assign beat_acc  = beat_valid && beat_ready;
  assign st_acc    = st_valid && st_ready;
  assign last_beat = beat_acc && (cnt_q == WORD_IDX'(WORDS - 1));

  always_comb begin
    state_d      = state_q;
    row_d        = row_q;
    ptr_d        = ptr_q;
    cnt_d        = cnt_q;
    smask_d      = smask_q;
    line_d       = line_q;
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    done_d       = 1'b0;
    we_d         = '0;
    waddr_d      = waddr_q;
    wdata_d      = wdata_q;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          row_d   = req_row;
          ptr_d   = req_word;
          cnt_d   = '0;
          smask_d = '0;
          state_d = FILL;
        end
      end
      FILL: begin
        if (beat_acc) begin
          // A word already written by a store keeps the store data.
          if (!smask_q[ptr_q]) line_d[ptr_q] = beat_data;
          ptr_d = ptr_q + 1'b1;  // WORDS is a power of two, so this wraps
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == '0) begin
            crit_valid_d = 1'b1;
            crit_data_d  = beat_data;  // raw memory data, even if a store hits it
          end
        end
        // Applied after the beat so a same-cycle store to the same word wins.
        if (st_acc) begin
          line_d[st_word]  = st_data;
          smask_d[st_word] = 1'b1;
        end
        if (last_beat) begin
          state_d = WRITE;
          we_d    = '1;
          done_d  = 1'b1;
          waddr_d = row_q;
          wdata_d = line_d;  // includes the final beat and any same-cycle store
        end
      end
      WRITE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      row_q        <= '0;
      ptr_q        <= '0;
      cnt_q        <= '0;
      smask_q      <= '0;
      line_q       <= '0;
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
      done_q       <= 1'b0;
      we_q         <= '0;
      waddr_q      <= '0;
      wdata_q      <= '0;
    end else begin
      state_q      <= state_d;
      row_q        <= row_d;
      ptr_q        <= ptr_d;
      cnt_q        <= cnt_d;
      smask_q      <= smask_d;
      line_q       <= line_d;
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
      done_q       <= done_d;
      we_q         <= we_d;
      waddr_q      <= waddr_d;
      wdata_q      <= wdata_d;
    end
  end

  assign crit_valid  = crit_valid_q;
  assign crit_data   = crit_data_q;
  assign done        = done_q;
  assign writeEnable = we_q;
  assign writeAddr   = waddr_q;
  assign writeData   = wdata_q;

endmodule

// File: tb/tb_dcache_fill_buffer.sv
// Purpose: self-checking bench for dcache_fill_buffer against a word-level line model.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_dcache_fill_buffer;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [8:0]   req_row = '0;
  logic [2:0]   req_word = '0;
  logic         beat_valid = 1'b0;
  logic         beat_ready;
  logic [63:0]  beat_data = '0;
  logic         st_valid = 1'b0;
  logic         st_ready;
  logic [2:0]   st_word = '0;
  logic [63:0]  st_data = '0;
  logic         crit_valid;
  logic [63:0]  crit_data;
  logic         busy;
  logic         done;
  logic [8:0]   writeAddr;
  logic [511:0] writeData;
  logic [7:0]   writeEnable;

  dcache_fill_buffer dut (
    .clk(clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_row(req_row), .req_word(req_word),
    .beat_valid(beat_valid), .beat_ready(beat_ready), .beat_data(beat_data),
    .st_valid(st_valid), .st_ready(st_ready), .st_word(st_word), .st_data(st_data),
    .crit_valid(crit_valid), .crit_data(crit_data), .busy(busy), .done(done),
    .writeAddr(writeAddr), .writeData(writeData), .writeEnable(writeEnable)
  );

  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // Event counters sampled on the falling edge.
  int we_cnt = 0, done_cnt = 0, crit_cnt = 0;
  always @(negedge clk) begin
    if (writeEnable != 8'h00) we_cnt++;
    if (done) done_cnt++;
    if (crit_valid) crit_cnt++;
  end

  // Per-line schedule: beat k data, idle cycles before beat k, and an optional store
  // either in its own cycle just before beat k or in the same cycle as beat k.
  logic [63:0] bd [8];
  int          gap [8];
  bit          st_en [8];
  bit          st_same [8];
  logic [2:0]  st_w [8];
  logic [63:0] st_d [8];

  task automatic clear_sched();
    for (int k = 0; k < 8; k++) begin
      bd[k] = '0; gap[k] = 0; st_en[k] = 0; st_same[k] = 0; st_w[k] = '0; st_d[k] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fill_line(input logic [8:0] row, input logic [2:0] word,
                           input bit hold, input logic [8:0] hold_row, input string tag);
    logic [63:0]  exp_w [8];
    logic [511:0] exp_vec;
    int we0, done0, crit0;
    // Reference: beat k lands on word (word+k) mod 8; any store to a word overrides
    // memory data, later stores override earlier ones.
    for (int k = 0; k < 8; k++) exp_w[(int'(word) + k) % 8] = bd[k];
    for (int k = 0; k < 8; k++) if (st_en[k]) exp_w[st_w[k]] = st_d[k];
    for (int i = 0; i < 8; i++) exp_vec[i*64 +: 64] = exp_w[i];
    we0 = we_cnt; done0 = done_cnt; crit0 = crit_cnt;

    req_row = row; req_word = word; req_valid = 1'b1;
    chk_cnt++;
    if (req_ready !== 1'b1) $display("FAIL %s req_ready_idle: got %b want 1", tag, req_ready);
    else pass_cnt++;
    tick();
    if (hold) req_row = hold_row;
    else req_valid = 1'b0;
    chk_cnt++;
    if (busy !== 1'b1) $display("FAIL %s busy_fill: got %b want 1", tag, busy);
    else pass_cnt++;

    for (int k = 0; k < 8; k++) begin
      repeat (gap[k]) tick();
      if (st_en[k] && !st_same[k]) begin
        st_valid = 1'b1; st_word = st_w[k]; st_data = st_d[k];
        tick();
        st_valid = 1'b0;
      end
      beat_valid = 1'b1; beat_data = bd[k];
      if (st_en[k] && st_same[k]) begin
        st_valid = 1'b1; st_word = st_w[k]; st_data = st_d[k];
      end
      if (hold) begin
        chk_cnt++;
        if (req_ready !== 1'b0) $display("FAIL %s req_ready_in_fill: got %b want 0", tag, req_ready);
        else pass_cnt++;
      end
      tick();
      beat_valid = 1'b0; st_valid = 1'b0;
      if (k == 0) begin
        chk_cnt++;
        if (crit_valid !== 1'b1 || crit_data !== bd[0])
          $display("FAIL %s crit: got v=%b d=%h want v=1 d=%h", tag, crit_valid, crit_data, bd[0]);
        else pass_cnt++;
      end
    end

    // Cycle N+1: the SRAM write.
    chk_cnt++;
    if (writeEnable !== 8'hFF || writeAddr !== row || done !== 1'b1)
      $display("FAIL %s write_ctl: got we=%h addr=%0d done=%b want we=ff addr=%0d done=1",
               tag, writeEnable, writeAddr, done, row);
    else pass_cnt++;
    chk_cnt++;
    if (writeData !== exp_vec)
      for (int i = 0; i < 8; i++)
        if (writeData[i*64 +: 64] !== exp_w[i])
          $display("FAIL %s write_data word%0d: got %h want %h", tag, i, writeData[i*64 +: 64], exp_w[i]);
    if (writeData === exp_vec) pass_cnt++;
    chk_cnt++;
    if (beat_ready !== 1'b0 || st_ready !== 1'b0 || req_ready !== 1'b0)
      $display("FAIL %s ready_in_write: got beat=%b st=%b req=%b want 0 0 0",
               tag, beat_ready, st_ready, req_ready);
    else pass_cnt++;

    // Cycle N+2: back in IDLE.
    tick();
    chk_cnt++;
    if (writeEnable !== 8'h00 || done !== 1'b0 || req_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s after_write: got we=%h done=%b req_ready=%b busy=%b want 00 0 1 0",
               tag, writeEnable, done, req_ready, busy);
    else pass_cnt++;
    chk_cnt++;
    if (we_cnt - we0 != 1 || done_cnt - done0 != 1 || crit_cnt - crit0 != 1)
      $display("FAIL %s pulse_counts: got we=%0d done=%0d crit=%0d want 1 1 1",
               tag, we_cnt - we0, done_cnt - done0, crit_cnt - crit0);
    else pass_cnt++;
    chk_cnt++;
    if (crit_data !== bd[0]) $display("FAIL %s crit_held: got %h want %h", tag, crit_data, bd[0]);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    #2;
    chk_cnt++;
    if (writeEnable !== 8'h00 || writeAddr !== 9'd0 || writeData !== 512'd0 ||
        crit_valid !== 1'b0 || crit_data !== 64'd0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset_outputs: got we=%h addr=%0d crit=%b/%h done=%b busy=%b want all 0",
               writeEnable, writeAddr, crit_valid, crit_data, done, busy);
    else pass_cnt++;
    chk_cnt++;
    if (req_ready !== 1'b1 || beat_ready !== 1'b0 || st_ready !== 1'b0)
      $display("FAIL reset_ready: got req=%b beat=%b st=%b want 1 0 0", req_ready, beat_ready, st_ready);
    else pass_cnt++;
    repeat (2) @(posedge clk);
    #3 reset_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    clear_sched();
    for (int k = 0; k < 8; k++) bd[k] = 64'h10 + 64'(k);
    fill_line(9'd5, 3'd0, 1'b0, 9'd0, "basic");
  endtask

  task automatic test_wrap();
    clear_sched();
    for (int k = 0; k < 8; k++) bd[k] = 64'hA0A0_0000_0000_00A0 + 64'(k);
    fill_line(9'd511, 3'd6, 1'b0, 9'd0, "wrap");
  endtask

  task automatic test_store_merge();
    clear_sched();
    for (int k = 0; k < 8; k++) bd[k] = 64'h5500 + 64'(k);
    // Store to word 3 before its beat; store to word 1 after its beat.
    st_en[1] = 1; st_same[1] = 0; st_w[1] = 3'd3; st_d[1] = 64'hDEAD;
    st_en[2] = 1; st_same[2] = 0; st_w[2] = 3'd1; st_d[2] = 64'hBEEF_0001;
    fill_line(9'd42, 3'd0, 1'b0, 9'd0, "store_merge");
  endtask

  task automatic test_same_cycle_gaps();
    clear_sched();
    for (int k = 0; k < 8; k++) begin
      bd[k]  = {$urandom, $urandom};
      gap[k] = $urandom_range(0, 5);
    end
    st_en[2] = 1; st_same[2] = 1; st_w[2] = 3'd2; st_d[2] = 64'hC0FFEE;
    fill_line(9'd100, 3'd0, 1'b0, 9'd0, "same_cycle");
  endtask

  task automatic test_reset_mid_fill();
    int we0;
    clear_sched();
    we0 = we_cnt;
    req_row = 9'd9; req_word = 3'd4; req_valid = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      beat_valid = 1'b1; beat_data = 64'h7700 + 64'(k);
      tick();
    end
    // Keep offering beats and stores through reset; none may be taken.
    st_valid = 1'b1; st_word = 3'd0; st_data = 64'h1;
    #2 reset_n = 1'b0;
    #1;
    chk_cnt++;
    if (writeEnable !== 8'h00 || writeAddr !== 9'd0 || writeData !== 512'd0 ||
        crit_valid !== 1'b0 || crit_data !== 64'd0 || done !== 1'b0 || busy !== 1'b0)
      $display("FAIL midfill_reset_outputs: got we=%h addr=%0d crit=%b/%h done=%b busy=%b want all 0",
               writeEnable, writeAddr, crit_valid, crit_data, done, busy);
    else pass_cnt++;
    repeat (3) @(posedge clk);
    #3 reset_n = 1'b1;
    repeat (6) tick();
    beat_valid = 1'b0; st_valid = 1'b0;
    chk_cnt++;
    if (we_cnt != we0 || busy !== 1'b0)
      $display("FAIL midfill_no_write: got we_pulses=%0d busy=%b want 0 0", we_cnt - we0, busy);
    else pass_cnt++;
    for (int k = 0; k < 8; k++) bd[k] = 64'h3300 + 64'(k);
    fill_line(9'd9, 3'd4, 1'b0, 9'd0, "after_reset");
  endtask

  task automatic test_back_to_back();
    clear_sched();
    for (int k = 0; k < 8; k++) bd[k] = 64'h6600 + 64'(k);
    fill_line(9'd33, 3'd2, 1'b1, 9'd77, "b2b_first");
    clear_sched();
    for (int k = 0; k < 8; k++) bd[k] = 64'h8800 + 64'(k);
    fill_line(9'd77, 3'd5, 1'b0, 9'd0, "b2b_second");
  endtask

  task automatic test_random();
    for (int n = 0; n < 8; n++) begin
      logic [8:0] row;
      logic [2:0] word;
      clear_sched();
      row  = 9'($urandom_range(0, 511));
      word = 3'($urandom_range(0, 7));
      for (int k = 0; k < 8; k++) begin
        bd[k]  = {$urandom, $urandom};
        gap[k] = $urandom_range(0, 3);
        if ($urandom_range(0, 2) == 0) begin
          st_en[k]   = 1;
          st_same[k] = 1'($urandom_range(0, 1));
          st_w[k]    = 3'($urandom_range(0, 7));
          st_d[k]    = {$urandom, $urandom};
        end
      end
      fill_line(row, word, 1'b0, 9'd0, "random");
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_store_merge();
    test_same_cycle_gaps();
    test_reset_mid_fill();
    test_back_to_back();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
